// File: rtl/regfile_32x32_if.sv
// Writeback/operand-fetch bus for the 32x32 register file.
// master = pipeline side, slave = register file.
interface regfile_32x32_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
);
  localparam int AW = $clog2(NREGS);

  logic              wr_en;
  logic [NREGS-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [AW-1:0]     rd_addr_a;
  logic [AW-1:0]     rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              sel_err;
  logic [15:0]       wr_count;

  modport master (
    output wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, sel_err, wr_count
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, sel_err, wr_count
  );
endinterface

// File: rtl/regfile_32x32.sv
// MIPS 32x32 register file: one-hot write strobe from the rd decoder, two
// combinational read ports with optional same-cycle bypass, sticky select fault.
module regfile_32x32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_32x32_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         sel_onehot;
  logic                         commit;
  logic                         bad_sel;
  logic                         hit_a, hit_b;
  logic [DATA_W-1:0]            data_a, data_b;
  logic                         sel_err;
  logic [15:0]                  wr_count;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign sel_onehot = (bus.wr_sel != '0) &&
                      ((bus.wr_sel & (bus.wr_sel - NREGS'(1))) == '0);
  assign commit  = bus.wr_en &&  sel_onehot;
  assign bad_sel = bus.wr_en && !sel_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (commit) begin
      // Entry 0 is never loaded, so it holds the reset zero forever.
      for (int i = 1; i < NREGS; i++)
        if (bus.wr_sel[i]) regs[i] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      if (bad_sel) sel_err <= 1'b1;
      if (commit)  wr_count <= wr_count + 16'd1;
    end
  end

  assign hit_a = BYPASS && commit && bus.wr_sel[bus.rd_addr_a];
  assign hit_b = BYPASS && commit && bus.wr_sel[bus.rd_addr_b];

  always_comb begin
    data_a = regs[bus.rd_addr_a];
    data_b = regs[bus.rd_addr_b];
    if (hit_a) data_a = bus.wr_data;
    if (hit_b) data_b = bus.wr_data;
    if (bus.rd_addr_a == AW'(0)) data_a = '0;
    if (bus.rd_addr_b == AW'(0)) data_b = '0;
  end

  assign bus.rd_data_a = data_a;
  assign bus.rd_data_b = data_b;
  assign bus.sel_err   = sel_err;
  assign bus.wr_count  = wr_count;
endmodule
